// File: rtl/sar_pkg.sv
// sar_pkg: shared FSM state type, default resolution and bit-index width helper for sar_logic.
package sar_pkg;
  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;
  localparam int SAR_WIDTH_DEF = 8;
  function automatic int idx_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/sar_logic.sv
// sar_logic: MSB-first successive-approximation register driving the DAC and latching the result.
// Define SAR_RESTART_EN to let conv_start abort and restart a conversion in progress.
module sar_logic
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             conv_start,
  input  logic             comp_in,
  output logic [WIDTH-1:0] dac_code,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);
  localparam int IW = idx_w(WIDTH);
  localparam logic [IW-1:0] TOP = IW'(WIDTH - 1);
  state_t state;
  logic [IW-1:0] bit_idx;
  logic [WIDTH-1:0] code_nxt;
  logic restart;
`ifdef SAR_RESTART_EN
  assign restart = conv_start && (state == SAMPLE || state == CONVERT);
`else
  assign restart = 1'b0;
`endif
  // Resolve the current bit and raise the next trial bit in one step.
  always_comb begin
    code_nxt = dac_code;
    if (!comp_in) code_nxt[bit_idx] = 1'b0;
    if (bit_idx != '0) code_nxt[bit_idx - 1'b1] = 1'b1;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      dac_code <= '0;
      result   <= '0;
      bit_idx  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (restart) begin
      state    <= SAMPLE;
      dac_code <= '0;
    end else begin
      case (state)
        IDLE: if (conv_start) begin
          state    <= SAMPLE;
          dac_code <= '0;
          busy     <= 1'b1;
        end
        SAMPLE: begin
          state    <= CONVERT;
          dac_code <= {1'b1, {(WIDTH-1){1'b0}}};
          bit_idx  <= TOP;
        end
        CONVERT: begin
          dac_code <= code_nxt;
          if (bit_idx == '0) begin
            state  <= DONE;
            result <= code_nxt;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else begin
            bit_idx <= bit_idx - 1'b1;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= conv_start ? SAMPLE : IDLE;
          if (conv_start) begin
            dac_code <= '0;
            busy     <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule
